jimbo_bus_if: RTL and testbench

//  Bus interface unit between the jimbo 4-bit core and the TinyTapeout pins. It accepts one

---
 rtl/jimbo_pkg.sv | 20 ++
 rtl/jimbo_pin_mux.sv | 22 ++
 rtl/jimbo_bus_if.sv | 117 +++++++++++
 tb/tb_jimbo_bus_if.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jimbo_pkg.sv
// Shared types and pin-map constants for the jimbo bus interface unit.
package jimbo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    HALTED
  } bus_state_e;

  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned DATA_W      = 4;
  localparam int unsigned ADDR_SPLIT  = 4;   // addr[3:0] rides on uio_out[7:4]
  localparam int unsigned UO_RW_BIT   = 7;
  localparam int unsigned UO_ADDR_MSB = 6;

  localparam logic [ADDR_W-1:0] HALT_ADDR_DEFAULT = 11'h7FF;

endpackage

// File: rtl/jimbo_pin_mux.sv
// Packs registered bus state into the TinyTapeout pin vectors.
module jimbo_pin_mux
  import jimbo_pkg::*;
(
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              oe,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  always_comb begin
    uo_out                   = '0;
    uo_out[UO_RW_BIT]        = rw;
    uo_out[UO_ADDR_MSB:0]    = addr[ADDR_W-1:ADDR_SPLIT];
    uio_out                  = {addr[ADDR_SPLIT-1:0], wdata};
    uio_oe                   = {4'hF, {DATA_W{oe}}};
  end

endmodule

// File: rtl/jimbo_bus_if.sv
// jimbo core <-> TinyTapeout multiplexed bus sequencer (SETUP/ACCESS/HOLD).
// Optional JIMBO_BUS_RDY_EN: ACCESS also waits for mem_rdy after the wait count.
module jimbo_bus_if
  import jimbo_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] HALT_ADDR   = HALT_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              halt,
  input  logic              mem_rdy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  bus_state_e        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic              oe_q;
  logic [3:0]        cnt_q;
  logic              access_done;
  logic [3:0]        unused_uio_hi;

  assign unused_uio_hi = uio_in[7:4];

`ifdef JIMBO_BUS_RDY_EN
  assign access_done = (cnt_q == '0) && mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign access_done    = (cnt_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (halt) begin
            state     <= HALTED;
            addr_q    <= HALT_ADDR;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            req_ready <= 1'b0;
          end else if (req_valid && req_ready) begin
            state     <= SETUP;
            we_q      <= req_we;
            addr_q    <= req_addr;
            if (req_we) data_q <= req_wdata;
            oe_q      <= req_we;
            rw_q      <= 1'b0;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          rw_q  <= we_q;
          cnt_q <= 4'(WAIT_CYCLES);
        end
        ACCESS: begin
          if (access_done) begin
            state     <= HOLD;
            rw_q      <= 1'b0;
            rsp_valid <= 1'b1;
            if (!we_q) rsp_rdata <= uio_in[DATA_W-1:0];
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          // ready is withheld if halt is already up so the IDLE cycle only parks the bus
          state     <= IDLE;
          oe_q      <= 1'b0;
          req_ready <= ~halt;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  jimbo_pin_mux u_pin_mux (
    .rw      (rw_q),
    .addr    (addr_q),
    .wdata   (data_q),
    .oe      (oe_q),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

endmodule

// File: tb/tb_jimbo_bus_if.sv
// Scoreboarded bench for jimbo_bus_if: a WAIT_CYCLES=0 instance with a RAM model
// and a WAIT_CYCLES=2 instance with a fixed read pattern.
module tb_jimbo_bus_if;

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [3:0]  data;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid0, req_ready0, req_we0, halt0, mem_rdy0, rsp_valid0;
  logic [10:0] req_addr0;
  logic [3:0]  req_wdata0, rsp_rdata0;
  logic [7:0]  uio_in0, uo_out0, uio_out0, uio_oe0;

  logic        req_valid2, req_ready2, req_we2, halt2, mem_rdy2, rsp_valid2;
  logic [10:0] req_addr2;
  logic [3:0]  req_wdata2, rsp_rdata2;
  logic [7:0]  uio_in2, uo_out2, uio_out2, uio_oe2;

  jimbo_bus_if #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0), .halt(halt0),
    .mem_rdy(mem_rdy0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .uio_in(uio_in0), .uo_out(uo_out0), .uio_out(uio_out0), .uio_oe(uio_oe0)
  );

  jimbo_bus_if #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2), .halt(halt2),
    .mem_rdy(mem_rdy2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .uio_in(uio_in2), .uo_out(uo_out2), .uio_out(uio_out2), .uio_oe(uio_oe2)
  );

  // RAM on the pins of dut0; fixed pattern rdata = addr[3:0]^addr[7:4] on dut2
  logic [3:0]  ram [0:2047];
  logic [10:0] pin_addr0, pin_addr2;
  assign pin_addr0 = {uo_out0[6:0], uio_out0[7:4]};
  assign pin_addr2 = {uo_out2[6:0], uio_out2[7:4]};
  assign uio_in0   = {4'h0, ram[pin_addr0]};
  assign uio_in2   = {4'h0, pin_addr2[3:0] ^ pin_addr2[7:4]};
  always @(posedge clk) if (uo_out0[7]) ram[pin_addr0] <= uio_out0[3:0];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edges    = 0;
  exp_t        exp_q0[$], exp_q2[$];
  int unsigned hs_q0[$], hs_q2[$];
  int unsigned prev_hs2 = 0;
  bit          have_prev2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake recorder: edge index of every accepted request.
  always @(posedge clk) begin
    edges <= edges + 1;
    if (!rst_n) begin
      hs_q0.delete();
      hs_q2.delete();
    end else begin
      if (req_valid0 && req_ready0) hs_q0.push_back(edges + 1);
      if (req_valid2 && req_ready2) hs_q2.push_back(edges + 1);
    end
  end

  // Response monitors; current cycle index at a negedge is edges+1.
  always @(negedge clk) begin
    if (rst_n && rsp_valid0) begin
      exp_t e;
      int unsigned h;
      if (exp_q0.size() == 0 || hs_q0.size() == 0) begin
        check("rsp0_unexpected", 32'(rsp_valid0), 32'd0);
      end else begin
        e = exp_q0.pop_front();
        h = hs_q0.pop_front();
        check("rsp0_latency", edges + 1 - h, e.lat);
        if (e.we) check("rsp0_ram", 32'(ram[e.addr]), 32'(e.data));
        else      check("rsp0_rdata", 32'(rsp_rdata0), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid2) begin
      exp_t e;
      int unsigned h;
      if (exp_q2.size() == 0 || hs_q2.size() == 0) begin
        check("rsp2_unexpected", 32'(rsp_valid2), 32'd0);
      end else begin
        e = exp_q2.pop_front();
        h = hs_q2.pop_front();
        check("rsp2_latency", edges + 1 - h, e.lat);
        check("rsp2_rdata", 32'(rsp_rdata2), 32'(e.data));
        if (have_prev2) check("rsp2_hs_interval", h - prev_hs2, 32'd6);
        prev_hs2   <= h;
        have_prev2 <= 1'b1;
      end
    end
  end

  task automatic wait_ready0();
    int unsigned n = 0;
    while (!req_ready0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!req_ready0) begin
      n_fail++;
      $display("FAIL wait_ready0: req_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  // Leaves the caller at the negedge of the SETUP cycle.
  task automatic issue0(input logic we, input logic [10:0] a, input logic [3:0] wd,
                        input logic [3:0] ed, input int unsigned lat, input bit push);
    wait_ready0();
    req_valid0 = 1'b1;
    req_we0    = we;
    req_addr0  = a;
    req_wdata0 = wd;
    if (push) exp_q0.push_back('{we, a, ed, lat});
    @(negedge clk);
    req_valid0 = 1'b0;
  endtask

  logic [10:0] addrs2 [3];
  logic [3:0]  datas2 [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    halt0 = 1'b0; mem_rdy0 = 1'b1;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
    halt2 = 1'b0; mem_rdy2 = 1'b1;
    addrs2 = '{11'h010, 11'h0F3, 11'h7A5};
    datas2 = '{4'h1, 4'hC, 4'hF};

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_uo_out", 32'(uo_out0), 32'h00);
    check("rst_uio_out", 32'(uio_out0), 32'h00);
    check("rst_uio_oe", 32'(uio_oe0), 32'hF0);
    check("rst_req_ready", 32'(req_ready0), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata0), 32'd0);
    check("rst2_pins", {8'h0, uo_out2, uio_out2, uio_oe2}, 32'h0000F0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready0), 32'd1);

    // 2: write 0x123 <- 0xA
    issue0(1'b1, 11'h123, 4'hA, 4'hA, 3, 1'b1);
    check("wr_setup_uo_out", 32'(uo_out0), 32'h12);
    check("wr_setup_uio_out", 32'(uio_out0), 32'h3A);
    check("wr_setup_uio_oe", 32'(uio_oe0), 32'hFF);
    @(negedge clk);
    check("wr_access_uo_out", 32'(uo_out0), 32'h92);
    check("wr_access_uio_out", 32'(uio_out0), 32'h3A);
    @(negedge clk);
    check("wr_hold_uo_out", 32'(uo_out0), 32'h12);
    check("wr_hold_uio_out", 32'(uio_out0), 32'h3A);
    @(negedge clk);
    check("wr_idle_uio_oe", 32'(uio_oe0), 32'hF0);
    check("wr_idle_addr_kept", 32'(uo_out0), 32'h12);

    // 3: write 0x456 <- 5, read it back, then read 0x123
    issue0(1'b1, 11'h456, 4'h5, 4'h5, 3, 1'b1);
    issue0(1'b0, 11'h456, 4'h0, 4'h5, 3, 1'b1);
    check("rd_setup_uio_oe", 32'(uio_oe0), 32'hF0);
    check("rd_setup_uo_out", 32'(uo_out0), 32'h45);
    @(negedge clk);
    check("rd_access_uio_oe", 32'(uio_oe0), 32'hF0);
    check("rd_access_uo_out", 32'(uo_out0), 32'h45);
    @(negedge clk);
    check("rd_hold_uio_oe", 32'(uio_oe0), 32'hF0);
    issue0(1'b0, 11'h123, 4'h0, 4'hA, 3, 1'b1);

`ifdef JIMBO_BUS_RDY_EN
    issue0(1'b0, 11'h456, 4'h0, 4'h5, 8, 1'b1);
    mem_rdy0 = 1'b0;
    repeat (5) @(negedge clk);
    mem_rdy0 = 1'b1;
`endif

    // 4: WAIT_CYCLES=2, back-to-back reads with req_valid held
    req_valid2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int unsigned n;
      req_addr2 = addrs2[i];
      exp_q2.push_back('{1'b0, addrs2[i], datas2[i], 5});
      n = 0;
      while (!req_ready2 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("wait_ready2", 32'(req_ready2), 32'd1);
      @(negedge clk);
    end
    req_valid2 = 1'b0;
    check("b2b_uio_oe2", 32'(uio_oe2), 32'hF0);

    // 5: halt raised during a write
    issue0(1'b1, 11'h2C7, 4'h6, 4'h6, 3, 1'b1);
    halt0 = 1'b1;
    repeat (6) @(negedge clk);
    check("halt_uo_out", 32'(uo_out0), 32'h7F);
    check("halt_uio_addr_lo", 32'(uio_out0[7:4]), 32'hF);
    check("halt_uio_oe", 32'(uio_oe0), 32'hF0);
    check("halt_req_ready", 32'(req_ready0), 32'd0);
    req_valid0 = 1'b1;
    repeat (4) @(negedge clk);
    check("halt_req_ready_held", 32'(req_ready0), 32'd0);
    check("halt_no_pending", 32'(exp_q0.size()), 32'd0);
    req_valid0 = 1'b0;

    // 6: reset during ACCESS of a write
    rst_n = 1'b0;
    @(negedge clk);
    halt0 = 1'b0;
    rst_n = 1'b1;
    issue0(1'b1, 11'h055, 4'h3, 4'h0, 3, 1'b0);
    @(negedge clk);
    check("abort_access_rw", 32'(uo_out0[7]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rw", 32'(uo_out0[7]), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid0), 32'd0);
    check("abort_rsp_rdata", 32'(rsp_rdata0), 32'd0);
    check("abort_req_ready", 32'(req_ready0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", 32'(req_ready0), 32'd1);
    check("abort_no_rsp", 32'(rsp_valid0), 32'd0);

    repeat (8) @(negedge clk);
    check("drain_exp_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_exp_q2", 32'(exp_q2.size()), 32'd0);
    check("drain_hs_q0", 32'(hs_q0.size()), 32'd0);
    check("drain_hs_q2", 32'(hs_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
